// File: rtl/two_of_five_serial_tx.sv
// two_of_five_serial_tx: encodes one BCD digit into a 2-of-5 codeword
// (weights E1..E5 = 7-4-2-1-0) and shifts it out E1 first, each bit held
// CLK_DIV clocks. Optional macro START_STOP_EN adds a low start bit and a
// high stop bit around the five code bits and makes the line idle high.
//
// state | meaning
// IDLE  | line at idle level, digit_ready=1, waiting for a digit
// START | start bit (tx=0) for CLK_DIV clocks (START_STOP_EN only)
// SHIFT | code bit code[4-idx] on tx, tx_frame=1
// STOP  | stop bit (tx=1) for CLK_DIV clocks (START_STOP_EN only)
module two_of_five_serial_tx #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       tx,
  output logic       tx_frame,
  output logic [4:0] code,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef START_STOP_EN
    ,
    START = 2'd2,
    STOP  = 2'd3
`endif
  } state_t;

`ifdef START_STOP_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       code_d;
  logic             tx_d, frame_d, done_d, err_d, ready_d;

  logic accept, dig_ok, div_tc, last_bit;

  assign accept   = digit_valid && digit_ready;
  assign dig_ok   = (digit <= 4'd9);
  assign div_tc   = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit = (idx_q == 3'd4);

  function automatic logic [4:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 5'b11000;
      4'd1:    encode = 5'b00011;
      4'd2:    encode = 5'b00101;
      4'd3:    encode = 5'b00110;
      4'd4:    encode = 5'b01001;
      4'd5:    encode = 5'b01010;
      4'd6:    encode = 5'b01100;
      4'd7:    encode = 5'b10001;
      4'd8:    encode = 5'b10010;
      4'd9:    encode = 5'b10100;
      default: encode = 5'b00000;
    endcase
  endfunction

  // State, bit index and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state decode; only valid digits start a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && dig_ok) begin
`ifdef START_STOP_EN
          state_d = START;
`else
          state_d = SHIFT;
`endif
        end
      end
`ifdef START_STOP_EN
      START: if (div_tc) state_d = SHIFT;
      SHIFT: if (div_tc && last_bit) state_d = STOP;
      STOP:  if (div_tc) state_d = IDLE;
`else
      SHIFT: if (div_tc && last_bit) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Divider and bit index restart on every state change.
  always_comb begin
    div_d = '0;
    idx_d = '0;
    if (state_q != IDLE && state_d == state_q) begin
      div_d = div_tc ? '0 : div_q + 1'b1;
      idx_d = idx_q;
      if (state_q == SHIFT && div_tc) idx_d = idx_q + 3'd1;
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    code_d = code;
    if (accept && dig_ok) code_d = encode(digit);
    tx_d = IDLE_LVL;
    case (state_d)
      SHIFT:   tx_d = code_d[3'd4 - idx_d];
`ifdef START_STOP_EN
      START:   tx_d = 1'b0;
      STOP:    tx_d = 1'b1;
`endif
      default: tx_d = IDLE_LVL;
    endcase
    frame_d = (state_d == SHIFT);
    done_d  = (state_d == IDLE) && (state_q != IDLE);
    err_d   = accept && !dig_ok;
    ready_d = (state_d == IDLE);
  end

  // Output registers; nothing reaches a port combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code        <= '0;
      tx          <= IDLE_LVL;
      tx_frame    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      digit_ready <= 1'b1;
    end else begin
      code        <= code_d;
      tx          <= tx_d;
      tx_frame    <= frame_d;
      done        <= done_d;
      err         <= err_d;
      digit_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_two_of_five_serial_tx.sv
// Bench for two_of_five_serial_tx: a CLK_DIV=4 instance (a_*) and a
// CLK_DIV=1 instance (b_*) share clock and reset.
module tb_two_of_five_serial_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_digit = '0, b_digit = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, a_tx, a_frame, a_done, a_err;
  logic       b_ready, b_tx, b_frame, b_done, b_err;
  logic [4:0] a_code, b_code;

  two_of_five_serial_tx #(.CLK_DIV(4), .DIV_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .digit(a_digit), .digit_valid(a_valid),
    .digit_ready(a_ready), .tx(a_tx), .tx_frame(a_frame), .code(a_code),
    .done(a_done), .err(a_err)
  );

  two_of_five_serial_tx #(.CLK_DIV(1), .DIV_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .digit(b_digit), .digit_valid(b_valid),
    .digit_ready(b_ready), .tx(b_tx), .tx_frame(b_frame), .code(b_code),
    .done(b_done), .err(b_err)
  );

`ifdef START_STOP_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  typedef struct packed {
    logic tx;
    logic frame;
    logic done;
    logic ready;
    logic err;
  } samp_t;

  samp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Codeword from the weights: the unique pair summing to d; 0 uses E1+E2.
  function automatic logic [4:0] model_code(input int d);
    int w [5];
    logic [4:0] c;
    w = '{7, 4, 2, 1, 0};
    c = '0;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if ((d == 0 && i == 0 && j == 1) || (d != 0 && w[i] + w[j] == d)) begin
          c[4-i] = 1'b1;
          c[4-j] = 1'b1;
        end
    return c;
  endfunction

  // Expected per-cycle samples from the cycle after acceptance to the done cycle.
  function automatic void push_frame(input int d, input int div);
    logic [4:0] c;
    c = model_code(d);
`ifdef START_STOP_EN
    for (int k = 0; k < div; k++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < div; k++) exp_q.push_back('{c[4-b], 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef START_STOP_EN
    for (int k = 0; k < div; k++) exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
    exp_q.push_back('{IDLE_LVL, 1'b0, 1'b1, 1'b1, 1'b0});
  endfunction

  task automatic drain(input string tag, input bit sel_b);
    samp_t s;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      s = exp_q.pop_front();
      cmp({tag, "_tx"},    sel_b ? b_tx    : a_tx,    s.tx);
      cmp({tag, "_frame"}, sel_b ? b_frame : a_frame, s.frame);
      cmp({tag, "_done"},  sel_b ? b_done  : a_done,  s.done);
      cmp({tag, "_ready"}, sel_b ? b_ready : a_ready, s.ready);
      cmp({tag, "_err"},   sel_b ? b_err   : a_err,   s.err);
    end
  endtask

  task automatic send_a(input logic [3:0] d);
    @(negedge clk);
    a_digit = d;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    if (d <= 4'd9) push_frame(int'(d), 4);
  endtask

  initial begin
    bit seen_done;

    // Reset values
    repeat (3) @(negedge clk);
    cmp("rst_ready", a_ready, 1'b1);
    cmp("rst_tx", a_tx, IDLE_LVL);
    cmp("rst_frame", a_frame, 1'b0);
    cmp("rst_code", a_code, 5'b00000);
    cmp("rst_done", a_done, 1'b0);
    cmp("rst_err", a_err, 1'b0);
    cmp("rst_b_ready", b_ready, 1'b1);
    rst_n = 1'b1;

    // Single digit 0 at CLK_DIV=4
    send_a(4'd0);
    cmp("d0_code", a_code, model_code(0));
    drain("d0", 1'b0);

    // Digit 7 with digit 5 held valid throughout; 5 taken in the done cycle
    @(negedge clk);
    a_digit = 4'd7;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_digit = 4'd5;
    push_frame(7, 4);
    cmp("busy7_code", a_code, model_code(7));
    drain("busy7", 1'b0);
    cmp("busy7_code_hold", a_code, model_code(7));
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    push_frame(5, 4);
    cmp("busy5_code", a_code, model_code(5));
    drain("busy5", 1'b0);

    // Invalid digit 12 in IDLE
    send_a(4'd12);
    @(negedge clk);
    cmp("inv_err", a_err, 1'b1);
    cmp("inv_code", a_code, model_code(5));
    cmp("inv_tx", a_tx, IDLE_LVL);
    cmp("inv_frame", a_frame, 1'b0);
    cmp("inv_ready", a_ready, 1'b1);
    @(negedge clk);
    cmp("inv_err_end", a_err, 1'b0);
    cmp("inv_ready2", a_ready, 1'b1);
    cmp("inv_tx2", a_tx, IDLE_LVL);

    // Reset during bit 2 of digit 3, then digit 8
    send_a(4'd3);
    cmp("r3_code", a_code, model_code(3));
`ifdef START_STOP_EN
    repeat (14) @(negedge clk);
`else
    repeat (10) @(negedge clk);
`endif
    cmp("r3_pre_tx", a_tx, 1'b1);
    cmp("r3_pre_frame", a_frame, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    cmp("r3_tx", a_tx, IDLE_LVL);
    cmp("r3_frame", a_frame, 1'b0);
    cmp("r3_code_rst", a_code, 5'b00000);
    cmp("r3_ready", a_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_done) seen_done = 1'b1;
    end
    cmp("r3_no_done", seen_done, 1'b0);
    send_a(4'd8);
    cmp("r8_code", a_code, model_code(8));
    drain("r8", 1'b0);

    // Digits 0..9 back-to-back at CLK_DIV=1
    @(negedge clk);
    b_digit = 4'd0;
    b_valid = 1'b1;
    for (int d = 0; d < 10; d++) begin
      @(posedge clk);
      #1;
      if (d == 9) b_valid = 1'b0;
      else b_digit = 4'(d + 1);
      push_frame(d, 1);
      cmp("tbl_code", b_code, model_code(d));
      cmp("tbl_ones", 8'($countones(b_code)), 8'd2);
      drain("tbl", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
